// File: rtl/flow_install_ctrl.sv
// Flow install controller: arbitrates CPU/RX install requests, writes lookup then state tables, tracks active flows.
// Latency: accept T, check T+1, lookup write T+2, state write T+3, done/err report T+4, next accept T+5.
// Backpressure: requests accepted only in IDLE; lookup/state writes hold val and payload until the sink is ready.
module flow_install_ctrl #(
  parameter int FLOW_ID_W = 6,
  parameter int ENTRY_W   = 96,
  parameter int ACK_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 src0_req_val,
  output logic                 src0_req_rdy,
  input  logic [FLOW_ID_W-1:0] src0_req_flowid,
  input  logic [ENTRY_W-1:0]   src0_req_entry,
  input  logic [ACK_W-1:0]     src0_req_ack,
  input  logic                 src1_req_val,
  output logic                 src1_req_rdy,
  input  logic [FLOW_ID_W-1:0] src1_req_flowid,
  input  logic [ENTRY_W-1:0]   src1_req_entry,
  input  logic [ACK_W-1:0]     src1_req_ack,
  output logic                 lookup_wr_val,
  input  logic                 lookup_wr_rdy,
  output logic [FLOW_ID_W-1:0] lookup_wr_flowid,
  output logic [ENTRY_W-1:0]   lookup_wr_entry,
  output logic                 state_init_val,
  input  logic                 state_init_rdy,
  output logic [FLOW_ID_W-1:0] state_init_flowid,
  output logic [ACK_W-1:0]     state_init_ack,
  input  logic                 flow_free_val,
  input  logic [FLOW_ID_W-1:0] flow_free_flowid,
  output logic                 install_done_val,
  output logic                 install_err_val,
  output logic [FLOW_ID_W-1:0] install_flowid,
  output logic                 install_src,
  output logic [FLOW_ID_W:0]   active_cnt
);

  localparam int NUM_FLOWS = 2 ** FLOW_ID_W;
  localparam logic [FLOW_ID_W:0] CNT_ONE = {{FLOW_ID_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, CHECK, WR_LOOKUP, WR_STATE, DONE, ERR} state_t;

  state_t                 state, state_nxt;
  logic                   ptr;
  logic                   grant;
  logic                   accept;
  logic [NUM_FLOWS-1:0]   bitmap;
  logic [FLOW_ID_W-1:0]   hold_flowid;
  logic [ENTRY_W-1:0]     hold_entry;
  logic [ACK_W-1:0]       hold_ack;
  logic                   hold_src;
  logic                   do_set;
  logic                   do_clr;

  // Round-robin pick: a lone requester wins, a tie goes to the pointer; idle default is the pointer.
  always_comb begin
    grant = ptr;
    if (src0_req_val && !src1_req_val) grant = 1'b0;
    else if (src1_req_val && !src0_req_val) grant = 1'b1;
  end

  assign accept = grant ? (src1_req_val && src1_req_rdy) : (src0_req_val && src0_req_rdy);
  assign do_set = (state == DONE);
  // Only a currently-set bit can be freed; CHECK sees the registered (pre-free) bitmap.
  assign do_clr = flow_free_val && bitmap[flow_free_flowid];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = CHECK;
      CHECK:     state_nxt = bitmap[hold_flowid] ? ERR : WR_LOOKUP;
      WR_LOOKUP: if (lookup_wr_rdy) state_nxt = WR_STATE;
      WR_STATE:  if (state_init_rdy) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      ERR:       state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; payloads are zero whenever their valid is low.
  always_comb begin
    src0_req_rdy      = (state == IDLE) && !rst && !grant;
    src1_req_rdy      = (state == IDLE) && !rst && grant;
    lookup_wr_val     = (state == WR_LOOKUP);
    lookup_wr_flowid  = lookup_wr_val ? hold_flowid : '0;
    lookup_wr_entry   = lookup_wr_val ? hold_entry : '0;
    state_init_val    = (state == WR_STATE);
    state_init_flowid = state_init_val ? hold_flowid : '0;
    state_init_ack    = state_init_val ? hold_ack : '0;
    install_done_val  = (state == DONE);
    install_err_val   = (state == ERR);
    install_flowid    = (install_done_val || install_err_val) ? hold_flowid : '0;
    install_src       = (install_done_val || install_err_val) ? hold_src : 1'b0;
  end

  // Capture the granted request and advance the arbitration pointer past it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= 1'b0;
      hold_flowid <= '0;
      hold_entry  <= '0;
      hold_ack    <= '0;
      hold_src    <= 1'b0;
    end else if (accept) begin
      ptr         <= ~grant;
      hold_src    <= grant;
      hold_flowid <= grant ? src1_req_flowid : src0_req_flowid;
      hold_entry  <= grant ? src1_req_entry : src0_req_entry;
      hold_ack    <= grant ? src1_req_ack : src0_req_ack;
    end
  end

  // Active bitmap and count; a same-id free during DONE is a no-op because that bit is still clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      bitmap     <= '0;
      active_cnt <= '0;
    end else begin
      if (do_clr) bitmap[flow_free_flowid] <= 1'b0;
      if (do_set) bitmap[hold_flowid] <= 1'b1;
      case ({do_set, do_clr})
        2'b10:   active_cnt <= active_cnt + CNT_ONE;
        2'b01:   active_cnt <= active_cnt - CNT_ONE;
        default: active_cnt <= active_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_flow_install_ctrl.sv
// Directed bench for flow_install_ctrl: install path, arbitration, duplicates, stalls, frees, reset abort.
// Inputs are driven 2 time units after each rising edge; outputs are sampled mid-cycle.
// Sinks are ready unless a step deliberately stalls them.
module tb_flow_install_ctrl;
  localparam int FW = 6;
  localparam int EW = 96;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          src0_req_val, src0_req_rdy;
  logic [FW-1:0] src0_req_flowid;
  logic [EW-1:0] src0_req_entry;
  logic [AW-1:0] src0_req_ack;
  logic          src1_req_val, src1_req_rdy;
  logic [FW-1:0] src1_req_flowid;
  logic [EW-1:0] src1_req_entry;
  logic [AW-1:0] src1_req_ack;
  logic          lookup_wr_val, lookup_wr_rdy;
  logic [FW-1:0] lookup_wr_flowid;
  logic [EW-1:0] lookup_wr_entry;
  logic          state_init_val, state_init_rdy;
  logic [FW-1:0] state_init_flowid;
  logic [AW-1:0] state_init_ack;
  logic          flow_free_val;
  logic [FW-1:0] flow_free_flowid;
  logic          install_done_val, install_err_val;
  logic [FW-1:0] install_flowid;
  logic          install_src;
  logic [FW:0]   active_cnt;

  int errors = 0;
  int checks = 0;

  flow_install_ctrl #(.FLOW_ID_W(FW), .ENTRY_W(EW), .ACK_W(AW)) dut (
    .clk(clk), .rst(rst),
    .src0_req_val(src0_req_val), .src0_req_rdy(src0_req_rdy),
    .src0_req_flowid(src0_req_flowid), .src0_req_entry(src0_req_entry), .src0_req_ack(src0_req_ack),
    .src1_req_val(src1_req_val), .src1_req_rdy(src1_req_rdy),
    .src1_req_flowid(src1_req_flowid), .src1_req_entry(src1_req_entry), .src1_req_ack(src1_req_ack),
    .lookup_wr_val(lookup_wr_val), .lookup_wr_rdy(lookup_wr_rdy),
    .lookup_wr_flowid(lookup_wr_flowid), .lookup_wr_entry(lookup_wr_entry),
    .state_init_val(state_init_val), .state_init_rdy(state_init_rdy),
    .state_init_flowid(state_init_flowid), .state_init_ack(state_init_ack),
    .flow_free_val(flow_free_val), .flow_free_flowid(flow_free_flowid),
    .install_done_val(install_done_val), .install_err_val(install_err_val),
    .install_flowid(install_flowid), .install_src(install_src),
    .active_cnt(active_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request on a source and return in the cycle after acceptance (the CHECK cycle).
  task automatic do_req(input logic src, input logic [FW-1:0] id, input logic [EW-1:0] ent,
                        input logic [AW-1:0] ack);
    logic got;
    got = 1'b0;
    if (src) begin
      src1_req_val = 1'b1; src1_req_flowid = id; src1_req_entry = ent; src1_req_ack = ack;
    end else begin
      src0_req_val = 1'b1; src0_req_flowid = id; src0_req_entry = ent; src0_req_ack = ack;
    end
    #1;
    for (int i = 0; i < 20; i++) begin
      if (src ? src1_req_rdy : src0_req_rdy) begin
        tick();
        got = 1'b1;
        break;
      end
      tick();
    end
    src0_req_val = 1'b0;
    src1_req_val = 1'b0;
    chk("accept", {127'b0, got}, 128'd1);
  endtask

  logic [EW-1:0] ent_a;
  logic [EW-1:0] ent_b;
  logic          a0, a1;

  initial begin
    ent_a = 96'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
    ent_b = 96'h0123_4567_89AB_CDEF_F00D_BEEF;
    rst = 1'b1;
    src0_req_val = 1'b0; src0_req_flowid = '0; src0_req_entry = '0; src0_req_ack = '0;
    src1_req_val = 1'b0; src1_req_flowid = '0; src1_req_entry = '0; src1_req_ack = '0;
    lookup_wr_rdy = 1'b1; state_init_rdy = 1'b1;
    flow_free_val = 1'b0; flow_free_flowid = '0;

    // Reset state
    tick(); tick();
    chk("rst_rdy0", {127'b0, src0_req_rdy}, 128'd0);
    chk("rst_rdy1", {127'b0, src1_req_rdy}, 128'd0);
    chk("rst_cnt", {121'b0, active_cnt}, 128'd0);
    chk("rst_lkv", {127'b0, lookup_wr_val}, 128'd0);
    chk("rst_stv", {127'b0, state_init_val}, 128'd0);
    chk("rst_done", {127'b0, install_done_val}, 128'd0);
    chk("rst_err", {127'b0, install_err_val}, 128'd0);
    chk("rst_ifid", {122'b0, install_flowid}, 128'd0);
    rst = 1'b0;
    #1;
    chk("idle_rdy0", {127'b0, src0_req_rdy}, 128'd1);
    chk("idle_rdy1", {127'b0, src1_req_rdy}, 128'd0);

    // Basic install of flowid 5 from src0
    do_req(1'b0, 6'd5, ent_a, 32'd1000);
    chk("b_t1_lkv", {127'b0, lookup_wr_val}, 128'd0);
    tick();
    chk("b_t2_lkv", {127'b0, lookup_wr_val}, 128'd1);
    chk("b_t2_lkid", {122'b0, lookup_wr_flowid}, 128'd5);
    chk("b_t2_lkent", {32'b0, lookup_wr_entry}, {32'b0, ent_a});
    tick();
    chk("b_t3_stv", {127'b0, state_init_val}, 128'd1);
    chk("b_t3_stid", {122'b0, state_init_flowid}, 128'd5);
    chk("b_t3_stack", {96'b0, state_init_ack}, 128'd1000);
    tick();
    chk("b_t4_done", {127'b0, install_done_val}, 128'd1);
    chk("b_t4_id", {122'b0, install_flowid}, 128'd5);
    chk("b_t4_src", {127'b0, install_src}, 128'd0);
    chk("b_t4_err", {127'b0, install_err_val}, 128'd0);
    tick();
    chk("b_t5_done", {127'b0, install_done_val}, 128'd0);
    chk("b_t5_cnt", {121'b0, active_cnt}, 128'd1);

    // Free flow 5, then a redundant free that must be ignored
    flow_free_val = 1'b1; flow_free_flowid = 6'd5;
    tick();
    flow_free_val = 1'b0;
    chk("free5_cnt", {121'b0, active_cnt}, 128'd0);
    flow_free_val = 1'b1;
    tick();
    flow_free_val = 1'b0;
    chk("free5_again_cnt", {121'b0, active_cnt}, 128'd0);

    // Duplicate install of flowid 7
    do_req(1'b0, 6'd7, ent_b, 32'd7);
    tick(); tick(); tick(); tick();
    chk("d7_cnt", {121'b0, active_cnt}, 128'd1);
    do_req(1'b1, 6'd7, ent_a, 32'd9);
    tick();
    chk("dup_err", {127'b0, install_err_val}, 128'd1);
    chk("dup_done", {127'b0, install_done_val}, 128'd0);
    chk("dup_id", {122'b0, install_flowid}, 128'd7);
    chk("dup_src", {127'b0, install_src}, 128'd1);
    chk("dup_lkv", {127'b0, lookup_wr_val}, 128'd0);
    tick();
    chk("dup_stv", {127'b0, state_init_val}, 128'd0);
    chk("dup_cnt", {121'b0, active_cnt}, 128'd1);

    // Both sources valid continuously after reset: grants alternate every 5 cycles
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    src0_req_val = 1'b1; src0_req_flowid = 6'd10; src0_req_entry = ent_a; src0_req_ack = 32'd1;
    src1_req_val = 1'b1; src1_req_flowid = 6'd40; src1_req_entry = ent_b; src1_req_ack = 32'd2;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (cyc % 5 == 0) begin
        chk("rr_rdy0", {127'b0, src0_req_rdy}, {127'b0, ((cyc / 5) % 2) == 0});
        chk("rr_rdy1", {127'b0, src1_req_rdy}, {127'b0, ((cyc / 5) % 2) == 1});
      end
      chk("rr_done", {127'b0, install_done_val}, {127'b0, (cyc % 5) == 4});
      if (cyc % 5 == 4) chk("rr_src", {127'b0, install_src}, {127'b0, ((cyc / 5) % 2) == 1});
      a0 = src0_req_rdy;
      a1 = src1_req_rdy;
      tick();
      if (a0) src0_req_flowid = src0_req_flowid + 6'd1;
      if (a1) src1_req_flowid = src1_req_flowid + 6'd1;
    end
    src0_req_val = 1'b0;
    src1_req_val = 1'b0;
    chk("rr_cnt", {121'b0, active_cnt}, 128'd4);

    // Lookup sink stalls 4 cycles
    lookup_wr_rdy = 1'b0;
    do_req(1'b0, 6'd20, ent_b, 32'd77);
    tick();
    for (int k = 0; k < 5; k++) begin
      lookup_wr_rdy = (k == 4);
      chk("st_lkv", {127'b0, lookup_wr_val}, 128'd1);
      chk("st_lkid", {122'b0, lookup_wr_flowid}, 128'd20);
      chk("st_lkent", {32'b0, lookup_wr_entry}, {32'b0, ent_b});
      tick();
    end
    chk("st_t7_stv", {127'b0, state_init_val}, 128'd1);
    chk("st_t7_lkv", {127'b0, lookup_wr_val}, 128'd0);
    tick();
    chk("st_t8_done", {127'b0, install_done_val}, 128'd1);
    chk("st_t8_id", {122'b0, install_flowid}, 128'd20);
    tick();
    chk("st_cnt", {121'b0, active_cnt}, 128'd5);

    // Free of the same flowid in the DONE cycle: bit stays set, count +1
    do_req(1'b1, 6'd7, ent_a, 32'd3);
    tick(); tick(); tick();
    flow_free_val = 1'b1; flow_free_flowid = 6'd7;
    chk("sf_done", {127'b0, install_done_val}, 128'd1);
    tick();
    flow_free_val = 1'b0;
    chk("sf_cnt", {121'b0, active_cnt}, 128'd6);
    flow_free_val = 1'b1;
    tick();
    flow_free_val = 1'b0;
    chk("sf_free_cnt", {121'b0, active_cnt}, 128'd5);

    // Free of a different flowid in the DONE cycle: both apply, count unchanged
    do_req(1'b0, 6'd30, ent_a, 32'd4);
    tick(); tick(); tick();
    flow_free_val = 1'b1; flow_free_flowid = 6'd10;
    chk("df_done", {127'b0, install_done_val}, 128'd1);
    tick();
    flow_free_val = 1'b0;
    chk("df_cnt", {121'b0, active_cnt}, 128'd5);

    // Free during CHECK: CHECK still sees the bit set and reports a duplicate
    do_req(1'b0, 6'd30, ent_b, 32'd5);
    flow_free_val = 1'b1; flow_free_flowid = 6'd30;
    tick();
    flow_free_val = 1'b0;
    chk("cf_err", {127'b0, install_err_val}, 128'd1);
    chk("cf_id", {122'b0, install_flowid}, 128'd30);
    chk("cf_cnt", {121'b0, active_cnt}, 128'd4);
    tick();

    // Reset during WR_STATE abandons the install
    state_init_rdy = 1'b0;
    do_req(1'b1, 6'd50, ent_a, 32'd6);
    tick(); tick();
    chk("ra_stv", {127'b0, state_init_val}, 128'd1);
    rst = 1'b1;
    state_init_rdy = 1'b1;
    tick();
    chk("ra_rst_done", {127'b0, install_done_val}, 128'd0);
    chk("ra_rst_stv", {127'b0, state_init_val}, 128'd0);
    chk("ra_rst_cnt", {121'b0, active_cnt}, 128'd0);
    rst = 1'b0;
    #1;
    chk("ra_rdy0", {127'b0, src0_req_rdy}, 128'd1);
    tick();
    chk("ra_done", {127'b0, install_done_val}, 128'd0);
    chk("ra_err", {127'b0, install_err_val}, 128'd0);
    chk("ra_cnt", {121'b0, active_cnt}, 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
